world_writer: RTL
=================

// Module: world_writer
// PURPOSE
//  Write side of the world memory: executes PLACE/REMOVE/CLEAR cube commands against the dual-port world RAM that the
//  world drawer scans. Scans for duplicates/free slots, writes {valid,x,y,z} entries, tracks live cube count.
//  Owns RAM port B; drawer reads port A. Commands are held off while the drawer is busy so a frame never sees a half edit.
// PARAMETERS
//  COORD_WIDTH   32   full fixed-point coord width; stored coords are the COORD_WIDTH/2 integer halves
//  WORLD_SIZE    100  number of entries in world RAM
//  WORLD_BITS    7    address width, >= clog2(WORLD_SIZE)
//  READ_LATENCY  2    cycles from mem_addr to valid mem_rdata
//  WORLD_EXTENT  64   legal coord range [0,WORLD_EXTENT) (used only with WORLD_WRITER_BOUNDS_EN)
// PORTS
//  clk_in       in   1               system clock
//  rst_n_in     in   1               synchronous reset, active-low
//  drawer_busy  in   1               world drawer mid-frame; blocks command acceptance
//  cmd_valid    in   1               command present
//  cmd_ready    out  1               accepting command
//  cmd_op       in   2               0 PLACE, 1 REMOVE, 2 CLEAR, 3 reserved (returns OK, no write)
//  cmd_x/y/z    in   COORD_WIDTH/2   signed cube corner
//  mem_addr     out  WORLD_BITS      RAM port B address
//  mem_rdata    in   3*COORD_WIDTH/2+1  {valid,x,y,z}
//  mem_we       out  1               write strobe
//  mem_wdata    out  3*COORD_WIDTH/2+1  write entry
//  busy         out  1               command in progress
//  done         out  1               one-cycle completion pulse
//  status       out  3               0 OK,1 DUPLICATE,2 FULL,3 NOT_FOUND,4 OUT_OF_BOUNDS; held until next done
//  cube_count   out  WORLD_BITS+1    live entries
// BEHAVIOUR
//  Reset: cmd_ready=0, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, status=OK, cube_count=0, state IDLE.
//   RAM contents are not touched; software issues CLEAR after reset. Reset mid-command aborts immediately, no further writes.
//  IDLE: cmd_ready = ~drawer_busy. Handshake on cmd_valid&cmd_ready: latch op/coords, busy=1, idx=0, free_found=0.
//  SCAN (PLACE/REMOVE): per entry, drive mem_addr=idx, wait READ_LATENCY cycles, compare -> READ_LATENCY+1 cycles/entry.
//   match = rdata.valid & coords equal. PLACE: match -> DUPLICATE, no write, early exit; first !valid idx recorded.
//   REMOVE: match -> WRITE all-zero entry at idx, count-1, OK, early exit.
//   idx==WORLD_SIZE-1 with no exit: PLACE writes {1,x,y,z} at first free idx, count+1, OK; no free -> FULL.
//   REMOVE -> NOT_FOUND.
//  WRITE: mem_we=1 for exactly one cycle with mem_addr/mem_wdata stable.
//  CLEAR: write zero to addr 0..WORLD_SIZE-1, one per cycle (WORLD_SIZE cycles), count=0, OK.
//  RESP: done=1 one cycle, status updated same cycle, busy=0; return to IDLE (cmd_ready earliest next cycle).
//  drawer_busy rising mid-command does not stall the command (drawer_busy gates acceptance only).
//  cube_count saturates at WORLD_SIZE and floors at 0.
// CONFIGURATION
//  WORLD_WRITER_BOUNDS_EN defined: PLACE with any coord <0 or >=WORLD_EXTENT goes straight to RESP (done 2 cycles
//   after handshake), status OUT_OF_BOUNDS, no RAM access. REMOVE/CLEAR unaffected.
//  Undefined: no range check; any signed coord is stored; code 4 never produced.
// STRUCTURE
//  world_pkg: world_entry_t packed struct {valid,x,y,z}, world_op_t enum, world_status_t enum,
//   ENTRY_W = 3*COORD_WIDTH/2+1 localparam.
//  One sub-module: world_entry_match (combinational entry vs. command coordinate compare, valid-qualified).
//  FSM states: IDLE, SCAN_ADDR, SCAN_WAIT, SCAN_CHECK, WRITE, CLEAR, RESP.
// TESTING (WORLD_SIZE=8, READ_LATENCY=2, behavioural RAM model)
//  1 reset, CLEAR -> 8 zero writes addr 0..7 on consecutive cycles, done, status OK, cube_count 0.
//  2 PLACE(1,2,3) on empty -> scan of all 8 entries, write addr 0 wdata {1,1,2,3}, OK, cube_count 1.
//    Repeat PLACE(1,2,3) -> DUPLICATE after 3 cycles, no mem_we.
//  3 PLACE 8 distinct cubes then PLACE(9,9,9) -> FULL after 24 scan cycles, no write, count 8.
//  4 REMOVE(1,2,3) at addr 0 -> zero written addr 0, count-1;
//    PLACE(4,4,4) reuses addr 0; REMOVE(7,7,7) absent -> NOT_FOUND.
//  5 drawer_busy=1 with cmd_valid held -> cmd_ready 0 for 10 cycles, accepted on first cycle after release;
//    rst_n_in low mid-scan -> mem_we 0, busy 0 next cycle.
//  6 WORLD_WRITER_BOUNDS_EN: PLACE(-1,0,0) and PLACE(64,0,0) -> OUT_OF_BOUNDS, done 2 cycles after handshake,
//    no RAM access; without the macro, PLACE(-1,0,0) -> OK.

Source files
------------

// File: rtl/world_pkg.sv
// Shared types for the world memory write path: entry layout, command opcodes,
// completion status codes and writer FSM states.
package world_pkg;

    localparam int WORLD_COORD_W = 32;
    localparam int WORLD_HALF_W  = WORLD_COORD_W / 2;
    localparam int ENTRY_W       = 3 * WORLD_HALF_W + 1;

    typedef struct packed {
        logic                    valid;
        logic [WORLD_HALF_W-1:0] x;
        logic [WORLD_HALF_W-1:0] y;
        logic [WORLD_HALF_W-1:0] z;
    } world_entry_t;

    typedef logic [ENTRY_W-1:0] world_entry_bits_t;

    typedef enum logic [1:0] {
        OP_PLACE  = 2'd0,
        OP_REMOVE = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_RSVD   = 2'd3
    } world_op_t;

    typedef enum logic [2:0] {
        ST_OK            = 3'd0,
        ST_DUPLICATE     = 3'd1,
        ST_FULL          = 3'd2,
        ST_NOT_FOUND     = 3'd3,
        ST_OUT_OF_BOUNDS = 3'd4
    } world_status_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SCAN_ADDR  = 3'd1,
        S_SCAN_WAIT  = 3'd2,
        S_SCAN_CHECK = 3'd3,
        S_WRITE      = 3'd4,
        S_CLEAR      = 3'd5,
        S_RESP       = 3'd6
    } world_state_t;

endpackage

// File: rtl/world_entry_match.sv
// Combinational compare of one RAM entry against the latched command coordinates.
// A hit requires the entry to be valid; free flags an empty slot.
module world_entry_match #(
    parameter int HALF_W = 16
) (
    input  logic [3*HALF_W:0]  entry_i,
    input  logic [HALF_W-1:0]  x_i,
    input  logic [HALF_W-1:0]  y_i,
    input  logic [HALF_W-1:0]  z_i,
    output logic               hit_o,
    output logic               free_o
);

    logic entry_valid;

    assign entry_valid = entry_i[3*HALF_W];
    assign free_o      = ~entry_valid;
    assign hit_o       = entry_valid & (entry_i[3*HALF_W-1:0] == {x_i, y_i, z_i});

endmodule

// File: rtl/world_writer.sv
// Write side of the world RAM (port B): PLACE / REMOVE / CLEAR cube commands, live count.
// Optional WORLD_WRITER_BOUNDS_EN rejects PLACE coordinates outside [0, WORLD_EXTENT).
//
//  state        | meaning
//  S_IDLE       | waiting for a command; ready unless the drawer is mid-frame
//  S_SCAN_ADDR  | drive the scan index onto mem_addr
//  S_SCAN_WAIT  | hold address while the RAM read pipeline fills
//  S_SCAN_CHECK | compare returned entry, decide exit / next index
//  S_WRITE      | single-cycle write strobe of the chosen entry
//  S_CLEAR      | zero one entry per cycle across the whole RAM
//  S_RESP       | done pulse, status visible, back to idle
module world_writer
    import world_pkg::*;
#(
    parameter int COORD_WIDTH  = WORLD_COORD_W,
    parameter int WORLD_SIZE   = 100,
    parameter int WORLD_BITS   = 7,
    parameter int READ_LATENCY = 2,
    parameter int WORLD_EXTENT = 64
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         drawer_busy,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [COORD_WIDTH/2-1:0]     cmd_x,
    input  logic [COORD_WIDTH/2-1:0]     cmd_y,
    input  logic [COORD_WIDTH/2-1:0]     cmd_z,
    output logic [WORLD_BITS-1:0]        mem_addr,
    input  logic [3*(COORD_WIDTH/2):0]   mem_rdata,
    output logic                         mem_we,
    output logic [3*(COORD_WIDTH/2):0]   mem_wdata,
    output logic                         busy,
    output logic                         done,
    output logic [2:0]                   status,
    output logic [WORLD_BITS:0]          cube_count
);

    localparam int HALF_W = COORD_WIDTH / 2;
    localparam int ENT_W  = 3 * HALF_W + 1;
    localparam int WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

    localparam logic [WORLD_BITS-1:0] LAST_IDX = WORLD_BITS'(WORLD_SIZE - 1);
    localparam logic [WORLD_BITS:0]   CNT_MAX  = (WORLD_BITS + 1)'(WORLD_SIZE);
    localparam logic [HALF_W-1:0]     EXT_U    = HALF_W'(WORLD_EXTENT);

`ifdef WORLD_WRITER_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    world_state_t            state_q, state_d;
    world_op_t               op_q, op_d;
    world_status_t           status_q, status_d;
    logic [HALF_W-1:0]       x_q, x_d, y_q, y_d, z_q, z_d;
    logic [WORLD_BITS-1:0]   idx_q, idx_d;
    logic [WORLD_BITS-1:0]   free_idx_q, free_idx_d;
    logic                    free_found_q, free_found_d;
    logic [WORLD_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic [WORLD_BITS:0]     count_q, count_d;

    logic                    hit;
    logic                    slot_free;
    logic                    last_idx;
    logic                    cmd_oob;
    logic                    accept;

    world_entry_match #(
        .HALF_W (HALF_W)
    ) u_match (
        .entry_i (mem_rdata),
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .hit_o   (hit),
        .free_o  (slot_free)
    );

    // Unsigned compare also catches negative coords: their sign bit puts them far above EXT_U.
    assign cmd_oob  = BOUNDS_EN & ((cmd_x >= EXT_U) | (cmd_y >= EXT_U) | (cmd_z >= EXT_U));
    assign last_idx = (idx_q == LAST_IDX);

    assign cmd_ready = rst_n_in & (state_q == S_IDLE) & ~drawer_busy;
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        status_d     = status_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        idx_d        = idx_q;
        free_idx_d   = free_idx_q;
        free_found_d = free_found_q;
        wr_addr_d    = wr_addr_q;
        wait_d       = wait_q;
        count_d      = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d         = world_op_t'(cmd_op);
                    x_d          = cmd_x;
                    y_d          = cmd_y;
                    z_d          = cmd_z;
                    idx_d        = '0;
                    free_found_d = 1'b0;
                    unique case (world_op_t'(cmd_op))
                        OP_PLACE: begin
                            if (cmd_oob) begin
                                status_d = ST_OUT_OF_BOUNDS;
                                state_d  = S_RESP;
                            end else begin
                                state_d  = S_SCAN_ADDR;
                            end
                        end
                        OP_REMOVE: state_d = S_SCAN_ADDR;
                        OP_CLEAR:  state_d = S_CLEAR;
                        default: begin
                            status_d = ST_OK;
                            state_d  = S_RESP;
                        end
                    endcase
                end
            end
            S_SCAN_ADDR: begin
                if (READ_LATENCY > 1) begin
                    wait_d  = WAIT_W'(READ_LATENCY - 2);
                    state_d = S_SCAN_WAIT;
                end else begin
                    state_d = S_SCAN_CHECK;
                end
            end
            S_SCAN_WAIT: begin
                if (wait_q == '0) begin
                    state_d = S_SCAN_CHECK;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_SCAN_CHECK: begin
                if (op_q == OP_PLACE) begin
                    if (hit) begin
                        status_d = ST_DUPLICATE;
                        state_d  = S_RESP;
                    end else begin
                        if (slot_free && !free_found_q) begin
                            free_found_d = 1'b1;
                            free_idx_d   = idx_q;
                        end
                        if (last_idx) begin
                            if (free_found_q) begin
                                wr_addr_d = free_idx_q;
                                state_d   = S_WRITE;
                            end else if (slot_free) begin
                                wr_addr_d = idx_q;
                                state_d   = S_WRITE;
                            end else begin
                                status_d  = ST_FULL;
                                state_d   = S_RESP;
                            end
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_SCAN_ADDR;
                        end
                    end
                end else begin
                    if (hit) begin
                        wr_addr_d = idx_q;
                        state_d   = S_WRITE;
                    end else if (last_idx) begin
                        status_d  = ST_NOT_FOUND;
                        state_d   = S_RESP;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        state_d   = S_SCAN_ADDR;
                    end
                end
            end
            S_WRITE: begin
                status_d = ST_OK;
                state_d  = S_RESP;
                if (op_q == OP_PLACE) begin
                    if (count_q != CNT_MAX) count_d = count_q + 1'b1;
                end else begin
                    if (count_q != '0) count_d = count_q - 1'b1;
                end
            end
            S_CLEAR: begin
                if (last_idx) begin
                    count_d  = '0;
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else begin
                    idx_d    = idx_q + 1'b1;
                end
            end
            S_RESP: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            op_q         <= OP_PLACE;
            status_q     <= ST_OK;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            idx_q        <= '0;
            free_idx_q   <= '0;
            free_found_q <= 1'b0;
            wr_addr_q    <= '0;
            wait_q       <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            status_q     <= status_d;
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
            idx_q        <= idx_d;
            free_idx_q   <= free_idx_d;
            free_found_q <= free_found_d;
            wr_addr_q    <= wr_addr_d;
            wait_q       <= wait_d;
            count_q      <= count_d;
        end
    end

    // RAM port B is driven purely from state so a reset drops the strobe on the very next cycle.
    assign mem_addr   = (state_q == S_WRITE) ? wr_addr_q : idx_q;
    assign mem_we     = (state_q == S_WRITE) | (state_q == S_CLEAR);
    assign mem_wdata  = ((state_q == S_WRITE) && (op_q == OP_PLACE)) ? {1'b1, x_q, y_q, z_q}
                                                                     : {ENT_W{1'b0}};
    assign busy       = (state_q != S_IDLE) & (state_q != S_RESP);
    assign done       = (state_q == S_RESP);
    assign status     = status_q;
    assign cube_count = count_q;

endmodule
